parking_lot_ctrl: RTL and testbench

PARKING_LOT_CTRL -- requirements
Module: parking_lot_ctrl

---
 rtl/parking_lot_ctrl_if.sv | 69 ++++++
 rtl/parking_lot_ctrl.sv | 231 +++++++++++++++++++++++
 tb/tb_parking_lot_ctrl.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/parking_lot_ctrl_if.sv
// -----------------------------------------------------------------------------
// parking_lot_ctrl_if
//   Bundles the barrier handshake and occupancy status of the parking lot
//   controller.
//
//   Sensor side (driven by the lot environment, master):
//     entry_req    level, car waiting at the entry sensor
//     entry_pass   1-cycle pulse, car cleared the entry barrier
//     exit_req     level, car waiting at the exit sensor
//     exit_pass    1-cycle pulse, car cleared the exit barrier
//   Controller side (driven by parking_lot_ctrl, slave):
//     entry_open / exit_open        barrier open commands
//     entry_reject / exit_reject    1-cycle refusal pulses (full / empty)
//     timeout_err                   1-cycle pulse, a barrier closed on timeout
//     count / free                  occupied / free slot counts
//     full / almost_full / empty    occupancy status flags
// -----------------------------------------------------------------------------
interface parking_lot_ctrl_if #(
    parameter int CNT_W = 8
);
    logic             entry_req;
    logic             entry_pass;
    logic             exit_req;
    logic             exit_pass;
    logic             entry_open;
    logic             exit_open;
    logic             entry_reject;
    logic             exit_reject;
    logic             timeout_err;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] free;
    logic             full;
    logic             almost_full;
    logic             empty;

    modport master (
        output entry_req,
        output entry_pass,
        output exit_req,
        output exit_pass,
        input  entry_open,
        input  exit_open,
        input  entry_reject,
        input  exit_reject,
        input  timeout_err,
        input  count,
        input  free,
        input  full,
        input  almost_full,
        input  empty
    );

    modport slave (
        input  entry_req,
        input  entry_pass,
        input  exit_req,
        input  exit_pass,
        output entry_open,
        output exit_open,
        output entry_reject,
        output exit_reject,
        output timeout_err,
        output count,
        output free,
        output full,
        output almost_full,
        output empty
    );
endinterface

// File: rtl/parking_lot_ctrl.sv
// -----------------------------------------------------------------------------
// parking_lot_ctrl
//   Controls the entry and exit barriers of a parking lot with CAPACITY slots
//   and keeps the occupancy count plus derived status flags.
//
//   Each barrier has its own IDLE -> OPEN -> WAIT_CLR machine. A request in
//   IDLE is either granted (barrier opens) or rejected (lot full for entry,
//   lot empty for exit). WAIT_CLR holds until the request drops, so a held
//   request yields exactly one grant or one reject. An open barrier closes on
//   a pass pulse (count updates) or after TIMEOUT cycles (timeout_err).
//   Every output is a flop; flags and free are computed from the next count
//   so they always agree with count in the same cycle.
//
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous, active-high; closes barriers immediately
//     bus    parking_lot_ctrl_if.slave (sensor inputs, barrier/status outputs)
// -----------------------------------------------------------------------------
module parking_lot_ctrl #(
    parameter int CAPACITY  = 10,
    parameter int CNT_W     = 8,
    parameter int ALMOST_TH = 2,
    parameter int TIMEOUT   = 100
) (
    input  logic                  clk,
    input  logic                  reset,
    parking_lot_ctrl_if.slave     bus
);

    localparam int               TMR_W     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CAP_C     = CNT_W'(CAPACITY);
    localparam logic             AF_RESET  = (CAPACITY <= ALMOST_TH);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_OPEN     = 2'd1,
        ST_WAIT_CLR = 2'd2
    } gate_state_e;

    // Occupancy update with saturation at both ends; simultaneous entry and
    // exit passes cancel out.
    function automatic logic [CNT_W-1:0] next_count(
        input logic [CNT_W-1:0] cur,
        input logic             inc,
        input logic             dec
    );
        logic [CNT_W-1:0] res;
        res = cur;
        if (inc && !dec && (cur < CAP_C)) begin
            res = cur + CNT_W'(1);
        end else if (dec && !inc && (cur != '0)) begin
            res = cur - CNT_W'(1);
        end
        return res;
    endfunction

    // ---------------- state and output registers ----------------
    gate_state_e      entry_state_q, entry_state_d;
    gate_state_e      exit_state_q,  exit_state_d;
    logic [TMR_W-1:0] entry_timer_q, entry_timer_d;
    logic [TMR_W-1:0] exit_timer_q,  exit_timer_d;
    logic             entry_open_q,   entry_open_d;
    logic             exit_open_q,    exit_open_d;
    logic             entry_reject_q, entry_reject_d;
    logic             exit_reject_q,  exit_reject_d;
    logic             timeout_err_q,  timeout_err_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] free_q,  free_d;
    logic             full_q,        full_d;
    logic             almost_full_q, almost_full_d;
    logic             empty_q,       empty_d;

    // Per-gate events feeding the shared count and error logic.
    logic entry_inc;
    logic exit_dec;
    logic entry_to;
    logic exit_to;

    logic entry_grant;
    logic exit_grant;

    assign entry_grant = (count_q < CAP_C);
    assign exit_grant  = (count_q != '0);

    // ---------------- entry FSM: next state ----------------
    always_comb begin
        entry_state_d  = entry_state_q;
        entry_timer_d  = '0;
        entry_open_d   = 1'b0;
        entry_reject_d = 1'b0;
        entry_inc      = 1'b0;
        entry_to       = 1'b0;
        case (entry_state_q)
            ST_IDLE: begin
                if (bus.entry_req) begin
                    if (entry_grant) begin
                        entry_state_d = ST_OPEN;
                        entry_open_d  = 1'b1;
                    end else begin
                        entry_reject_d = 1'b1;
                        entry_state_d  = ST_WAIT_CLR;
                    end
                end
            end
            ST_OPEN: begin
                // A pass on the final timer cycle wins over the timeout.
                if (bus.entry_pass) begin
                    entry_inc     = 1'b1;
                    entry_state_d = ST_WAIT_CLR;
                end else if (entry_timer_q == TMR_LAST) begin
                    entry_to      = 1'b1;
                    entry_state_d = ST_WAIT_CLR;
                end else begin
                    entry_timer_d = entry_timer_q + TMR_W'(1);
                    entry_open_d  = 1'b1;
                end
            end
            ST_WAIT_CLR: begin
                if (!bus.entry_req) begin
                    entry_state_d = ST_IDLE;
                end
            end
            default: begin
                entry_state_d = ST_IDLE;
            end
        endcase
    end

    // ---------------- exit FSM: next state ----------------
    always_comb begin
        exit_state_d  = exit_state_q;
        exit_timer_d  = '0;
        exit_open_d   = 1'b0;
        exit_reject_d = 1'b0;
        exit_dec      = 1'b0;
        exit_to       = 1'b0;
        case (exit_state_q)
            ST_IDLE: begin
                if (bus.exit_req) begin
                    if (exit_grant) begin
                        exit_state_d = ST_OPEN;
                        exit_open_d  = 1'b1;
                    end else begin
                        exit_reject_d = 1'b1;
                        exit_state_d  = ST_WAIT_CLR;
                    end
                end
            end
            ST_OPEN: begin
                if (bus.exit_pass) begin
                    exit_dec     = 1'b1;
                    exit_state_d = ST_WAIT_CLR;
                end else if (exit_timer_q == TMR_LAST) begin
                    exit_to      = 1'b1;
                    exit_state_d = ST_WAIT_CLR;
                end else begin
                    exit_timer_d = exit_timer_q + TMR_W'(1);
                    exit_open_d  = 1'b1;
                end
            end
            ST_WAIT_CLR: begin
                if (!bus.exit_req) begin
                    exit_state_d = ST_IDLE;
                end
            end
            default: begin
                exit_state_d = ST_IDLE;
            end
        endcase
    end

    // ---------------- occupancy and status ----------------
    // Flags derive from the next count so they land in the same cycle as it.
    always_comb begin
        count_d       = next_count(count_q, entry_inc, exit_dec);
        free_d        = CAP_C - count_d;
        full_d        = (count_d == CAP_C);
        empty_d       = (count_d == '0);
        almost_full_d = (32'(free_d) <= ALMOST_TH);
        // Both gates timing out together still give a single pulse.
        timeout_err_d = entry_to | exit_to;
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            entry_state_q  <= ST_IDLE;
            exit_state_q   <= ST_IDLE;
            entry_timer_q  <= '0;
            exit_timer_q   <= '0;
            entry_open_q   <= 1'b0;
            exit_open_q    <= 1'b0;
            entry_reject_q <= 1'b0;
            exit_reject_q  <= 1'b0;
            timeout_err_q  <= 1'b0;
            count_q        <= '0;
            free_q         <= CAP_C;
            full_q         <= 1'b0;
            almost_full_q  <= AF_RESET;
            empty_q        <= 1'b1;
        end else begin
            entry_state_q  <= entry_state_d;
            exit_state_q   <= exit_state_d;
            entry_timer_q  <= entry_timer_d;
            exit_timer_q   <= exit_timer_d;
            entry_open_q   <= entry_open_d;
            exit_open_q    <= exit_open_d;
            entry_reject_q <= entry_reject_d;
            exit_reject_q  <= exit_reject_d;
            timeout_err_q  <= timeout_err_d;
            count_q        <= count_d;
            free_q         <= free_d;
            full_q         <= full_d;
            almost_full_q  <= almost_full_d;
            empty_q        <= empty_d;
        end
    end

    assign bus.entry_open   = entry_open_q;
    assign bus.exit_open    = exit_open_q;
    assign bus.entry_reject = entry_reject_q;
    assign bus.exit_reject  = exit_reject_q;
    assign bus.timeout_err  = timeout_err_q;
    assign bus.count        = count_q;
    assign bus.free         = free_q;
    assign bus.full         = full_q;
    assign bus.almost_full  = almost_full_q;
    assign bus.empty        = empty_q;

endmodule

// File: tb/tb_parking_lot_ctrl.sv
// -----------------------------------------------------------------------------
// tb_parking_lot_ctrl
//   Directed scenarios followed by a long randomized run, every cycle checked
//   against a transaction-level model of the lot (integer occupancy, a
//   countdown per open barrier, and a "request consumed" latch per gate).
// -----------------------------------------------------------------------------
module tb_parking_lot_ctrl;

    localparam int CAP   = 3;
    localparam int CW    = 8;
    localparam int ALM   = 1;
    localparam int TOUT  = 8;

    logic clk;
    logic reset;

    parking_lot_ctrl_if #(.CNT_W(CW)) bus ();

    parking_lot_ctrl #(
        .CAPACITY  (CAP),
        .CNT_W     (CW),
        .ALMOST_TH (ALM),
        .TIMEOUT   (TOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state.
    int m_count;
    int e_left, x_left;      // remaining open cycles, 0 = barrier closed
    bit e_lat,  x_lat;       // request already served, waiting for it to drop
    bit m_erej, m_xrej, m_to;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_count = 0;
        e_left  = 0;
        x_left  = 0;
        e_lat   = 1'b0;
        x_lat   = 1'b0;
        m_erej  = 1'b0;
        m_xrej  = 1'b0;
        m_to    = 1'b0;
    endtask

    // One clock edge of lot behaviour, using the inputs present at the edge.
    task automatic model_step();
        int c0;
        bit inc, dec, eto, xto;
        c0 = m_count;
        inc = 0; dec = 0; eto = 0; xto = 0;
        m_erej = 0; m_xrej = 0;
        if (e_left > 0) begin
            if (bus.entry_pass) begin inc = 1; e_left = 0; end
            else if (e_left == 1) begin eto = 1; e_left = 0; end
            else e_left--;
        end else if (!e_lat) begin
            if (bus.entry_req) begin
                e_lat = 1;
                if (c0 < CAP) e_left = TOUT; else m_erej = 1;
            end
        end else if (!bus.entry_req) begin
            e_lat = 0;
        end
        if (x_left > 0) begin
            if (bus.exit_pass) begin dec = 1; x_left = 0; end
            else if (x_left == 1) begin xto = 1; x_left = 0; end
            else x_left--;
        end else if (!x_lat) begin
            if (bus.exit_req) begin
                x_lat = 1;
                if (c0 > 0) x_left = TOUT; else m_xrej = 1;
            end
        end else if (!bus.exit_req) begin
            x_lat = 0;
        end
        if (inc && !dec) m_count = c0 + 1;
        else if (dec && !inc) m_count = c0 - 1;
        m_to = eto | xto;
    endtask

    task automatic check_all();
        chk("entry_open",   bus.entry_open,   (e_left > 0));
        chk("exit_open",    bus.exit_open,    (x_left > 0));
        chk("entry_reject", bus.entry_reject, m_erej);
        chk("exit_reject",  bus.exit_reject,  m_xrej);
        chk("timeout_err",  bus.timeout_err,  m_to);
        chk("count",        bus.count,        m_count);
        chk("free",         bus.free,         CAP - m_count);
        chk("full",         bus.full,         (m_count == CAP));
        chk("empty",        bus.empty,        (m_count == 0));
        chk("almost_full",  bus.almost_full,  ((CAP - m_count) <= ALM));
        chk("count_range",  (bus.count <= CW'(CAP)), 1);
    endtask

    task automatic drive(input logic er, input logic ep, input logic xr, input logic xp);
        bus.entry_req  = er;
        bus.entry_pass = ep;
        bus.exit_req   = xr;
        bus.exit_pass  = xp;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    initial begin
        logic er, xr;
        reset = 1'b1;
        drive(0, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        chk("rst_free", bus.free, 3);
        chk("rst_empty", bus.empty, 1);
        chk("rst_almost_full", bus.almost_full, 0);
        reset = 1'b0;
        cycle();

        // Exit from an empty lot is refused once.
        drive(0, 0, 1, 0); cycle();
        chk("empty_exit_reject", bus.exit_reject, 1);
        chk("empty_exit_count", bus.count, 0);
        cycle();
        chk("empty_exit_reject_once", bus.exit_reject, 0);
        chk("empty_exit_no_open", bus.exit_open, 0);
        drive(0, 0, 0, 0); cycle();

        // Fill the lot.
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 0); cycle();
            chk("fill_open", bus.entry_open, 1);
            drive(1, 1, 0, 0); cycle();
            drive(0, 0, 0, 0); cycle();
        end
        chk("full_count", bus.count, 3);
        chk("full_flag", bus.full, 1);
        chk("full_free", bus.free, 0);
        drive(1, 0, 0, 0); cycle();
        chk("full_reject", bus.entry_reject, 1);
        chk("full_no_open", bus.entry_open, 0);
        cycle();
        chk("full_reject_once", bus.entry_reject, 0);
        chk("full_still_closed", bus.entry_open, 0);
        drive(0, 0, 0, 0); cycle();

        // Two exits bring the count down to 1.
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 1, 0); cycle();
            drive(0, 0, 1, 1); cycle();
            drive(0, 0, 0, 0); cycle();
        end
        chk("one_left", bus.count, 1);

        // Simultaneous entry and exit passes leave the count alone.
        drive(1, 0, 1, 0); cycle();
        chk("both_open_e", bus.entry_open, 1);
        chk("both_open_x", bus.exit_open, 1);
        drive(1, 1, 1, 1); cycle();
        chk("both_pass_count", bus.count, 1);
        chk("both_pass_free", bus.free, 2);
        chk("both_pass_af", bus.almost_full, 0);
        chk("both_pass_closed", bus.entry_open, 0);
        drive(0, 0, 0, 0); cycle();

        // Held entry request with no pass: open for exactly TIMEOUT cycles.
        drive(1, 0, 0, 0);
        for (int i = 0; i < TOUT; i++) begin
            cycle();
            chk("timeout_open_window", bus.entry_open, 1);
        end
        cycle();
        chk("timeout_closed", bus.entry_open, 0);
        chk("timeout_pulse", bus.timeout_err, 1);
        chk("timeout_count", bus.count, 1);
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("timeout_no_regrant", bus.entry_open, 0);
            chk("timeout_pulse_once", bus.timeout_err, 0);
        end
        drive(0, 0, 0, 0); cycle();
        drive(1, 0, 0, 0); cycle();
        chk("regrant_after_drop", bus.entry_open, 1);
        drive(1, 1, 0, 0); cycle();
        chk("count_two", bus.count, 2);
        drive(0, 0, 0, 0); cycle();

        // Reset with the barrier open, and a pass pending.
        drive(1, 0, 0, 0); cycle();
        chk("pre_reset_open", bus.entry_open, 1);
        #3;
        reset = 1'b1;
        bus.entry_pass = 1'b1;
        #1;
        model_reset();
        chk("async_reset_open", bus.entry_open, 0);
        chk("async_reset_count", bus.count, 0);
        chk("async_reset_empty", bus.empty, 1);
        check_all();
        @(posedge clk);
        #1;
        check_all();
        reset = 1'b0;
        bus.entry_pass = 1'b0;
        // Request held through reset is treated as a fresh one.
        cycle();
        chk("post_reset_grant", bus.entry_open, 1);
        drive(1, 1, 0, 0); cycle();
        drive(0, 0, 0, 0); cycle();

        // Randomized traffic.
        er = 1'b0;
        xr = 1'b0;
        for (int n = 0; n < 10000; n++) begin
            if ($urandom_range(0, 5) == 0) er = ~er;
            if ($urandom_range(0, 5) == 0) xr = ~xr;
            drive(er, ($urandom_range(0, 3) == 0), xr, ($urandom_range(0, 3) == 0));
            cycle();
        end
        drive(0, 0, 0, 0);
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
